alu_acc_ctrl: RTL and testbench

ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

---
 rtl/alu_acc_ctrl_if.sv | 27 ++
 rtl/alu_acc_ctrl.sv | 60 ++++++
 tb/tb_alu_acc_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_acc_ctrl_if.sv
// alu_acc_ctrl_if: instruction handshake, ALU operand/result and architectural status bundle
interface alu_acc_ctrl_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_s;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             alu_cout;
  logic [WIDTH-1:0] acc;
  logic             flag_z;
  logic             flag_c;
  logic             done;
  logic             err;
  logic [7:0]       op_cnt;
  modport master (
    output in_valid, in_op, in_data, alu_y, alu_zero, alu_cout,
    input  in_ready, alu_a, alu_b, alu_s, acc, flag_z, flag_c, done, err, op_cnt
  );
  modport slave (
    input  in_valid, in_op, in_data, alu_y, alu_zero, alu_cout,
    output in_ready, alu_a, alu_b, alu_s, acc, flag_z, flag_c, done, err, op_cnt
  );
endinterface

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: three-state accumulator controller driving an external combinational ALU
module alu_acc_ctrl #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  alu_acc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t     state;
  logic [3:0] op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      op           <= '0;
      bus.in_ready <= 1'b1;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_s    <= '0;
      bus.acc      <= '0;
      bus.flag_z   <= 1'b1;
      bus.flag_c   <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.op_cnt   <= '0;
    end else
      case (state)
        IDLE:
          if (bus.in_valid) begin
            state        <= ISSUE;
            bus.in_ready <= 1'b0;
            op           <= bus.in_op;
            bus.alu_a    <= bus.acc;
            bus.alu_b    <= bus.in_data;
            bus.alu_s    <= bus.in_op[2:0];
          end
        ISSUE: begin
          state      <= CAPTURE;
          bus.done   <= 1'b1;
          bus.op_cnt <= bus.op_cnt + {7'd0, bus.op_cnt != 8'hff};
          if (!op[3]) begin
            bus.acc    <= bus.alu_y;
            bus.flag_z <= bus.alu_zero;
            bus.flag_c <= bus.alu_cout;
          end else if (op == 4'b1000) begin
            bus.acc    <= bus.alu_b;
            bus.flag_z <= bus.alu_b == WIDTH'(0);
            bus.flag_c <= 1'b0;
          end else if (op == 4'b1001) begin
            bus.acc    <= '0;
            bus.flag_z <= 1'b1;
            bus.flag_c <= 1'b0;
          end else
            bus.err <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          bus.done     <= 1'b0;
          bus.in_ready <= 1'b1;
        end
      endcase
endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: directed and random instruction streams checked against an architectural model
module tb_alu_acc_ctrl;
  localparam int W = 4;
  logic clk = 0, rst_n = 0;
  int total = 0, bad = 0;
  logic [W-1:0] m_acc;
  logic m_z, m_c, m_err;
  int m_cnt;
  alu_acc_ctrl_if #(.WIDTH(W)) bus ();
  alu_acc_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [W:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] s);
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {1'b0, a} + 1;
      default: return {1'b0, b};
    endcase
  endfunction
  logic [W:0] alu_r;
  assign alu_r = alu_f(bus.alu_a, bus.alu_b, bus.alu_s);
  assign bus.alu_y = alu_r[W-1:0];
  assign bus.alu_cout = alu_r[W];
  assign bus.alu_zero = alu_r[W-1:0] == 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [3:0] op, input logic [W-1:0] d);
    logic [W:0] r;
    if (!op[3]) begin
      r = alu_f(m_acc, d, op[2:0]);
      m_acc = r[W-1:0]; m_z = r[W-1:0] == 0; m_c = r[W];
    end else if (op == 4'b1000) begin
      m_acc = d; m_z = d == 0; m_c = 0;
    end else if (op == 4'b1001) begin
      m_acc = 0; m_z = 1; m_c = 0;
    end else m_err = 1;
    m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
  endtask
  task automatic model_reset();
    m_acc = 0; m_z = 1; m_c = 0; m_err = 0; m_cnt = 0;
  endtask
  task automatic check_arch(input string tag);
    chk({tag, ".acc"}, 32'(bus.acc), 32'(m_acc));
    chk({tag, ".z"}, 32'(bus.flag_z), 32'(m_z));
    chk({tag, ".c"}, 32'(bus.flag_c), 32'(m_c));
    chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
    chk({tag, ".cnt"}, 32'(bus.op_cnt), 32'(m_cnt));
  endtask
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] d, input bit full);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 10) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("ready_timeout", 0, 1);
    bus.in_valid = 1; bus.in_op = op; bus.in_data = d;
    @(posedge clk); #1;
    bus.in_valid = 0;
    if (full) begin
      chk("issue.ready", 32'(bus.in_ready), 0);
      chk("issue.done", 32'(bus.done), 0);
      chk("issue.a", 32'(bus.alu_a), 32'(m_acc));
      chk("issue.b", 32'(bus.alu_b), 32'(d));
      chk("issue.s", 32'(bus.alu_s), 32'(op[2:0]));
    end
    model(op, d);
    @(posedge clk); #1;
    chk("cap.done", 32'(bus.done), 1);
    if (full) chk("cap.ready", 32'(bus.in_ready), 0);
    check_arch("cap");
    @(posedge clk); #1;
    chk("idle.done", 32'(bus.done), 0);
    chk("idle.ready", 32'(bus.in_ready), 1);
  endtask
  initial begin
    int acc_n, done_n;
    bus.in_valid = 0; bus.in_op = 0; bus.in_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(bus.in_ready), 1);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.a", 32'(bus.alu_a), 0);
    check_arch("rst");
    rst_n = 1;
    @(posedge clk); #1;
    chk("rel.ready", 32'(bus.in_ready), 1);
    do_op(4'b1000, 4'b0011, 1);
    do_op(4'b0000, 4'b0010, 1);
    do_op(4'b0001, 4'b1111, 1);
    do_op(4'b1000, 4'b1010, 1);
    do_op(4'b1001, 4'b0110, 1);
    do_op(4'b1000, 4'b0000, 1);
    do_op(4'b1000, 4'b0101, 1);
    do_op(4'b1100, 4'b0011, 1);
    do_op(4'b0100, 4'b0101, 1);
    do_op(4'b1001, 4'b0000, 1);
    chk("err.sticky", 32'(bus.err), 1);
    @(negedge clk);
    bus.in_valid = 1; bus.in_op = 4'b1000; bus.in_data = 4'b0111;
    @(posedge clk); #1;
    rst_n = 0; bus.in_valid = 0;
    #1;
    model_reset();
    chk("mid.done", 32'(bus.done), 0);
    check_arch("mid");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("mid.ready", 32'(bus.in_ready), 1);
    chk("mid.done2", 32'(bus.done), 0);
    check_arch("mid2");
    acc_n = 0; done_n = 0;
    @(negedge clk);
    bus.in_valid = 1; bus.in_op = 4'b0110; bus.in_data = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      chk("hold.ready", 32'(bus.in_ready), 32'(i % 3 == 0));
      if (bus.in_ready) acc_n++;
      @(posedge clk); #1;
      if (bus.done) done_n++;
      @(negedge clk);
    end
    bus.in_valid = 0;
    repeat (3) model(4'b0110, 4'b0000);
    chk("hold.accepts", 32'(acc_n), 3);
    chk("hold.dones", 32'(done_n), 3);
    check_arch("hold");
    for (int i = 0; i < 260; i++)
      do_op(4'($urandom_range(0, 15)), 4'($urandom), i < 40);
    chk("sat.cnt", 32'(bus.op_cnt), 255);
    do_op(4'b1001, 4'b0000, 1);
    chk("sat.hold", 32'(bus.op_cnt), 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
